pe_act_queue: RTL and testbench
===============================

// Module: pe_act_queue
// PURPOSE
//   Activation queue inside each PE, directly upstream of the PE controller's computation FSM.
//   Buffers {input-act index, value} entries delivered by the network interface.
//   Presents the head entry plus empty / next-cycle-empty flags to the computation FSM.
//   Provides backpressure (queue_rdy) to the router-side network interface.
// PARAMETERS
//   DATA_WIDTH   16  activation value width; matches PeDataBus
//   IDX_WIDTH    10  input activation index width; matches PeAddrBus
//   DEPTH        16  entries; power of two, >= 4
//   AFULL_MARGIN 2   queue_rdy deasserts when free slots <= AFULL_MARGIN
// PORTS
//   clk              in   1             system clock; all state updates on rising edge
//   rst              in   1             synchronous, active-high reset
//   push_act         in   1             network interface writes one entry this cycle
//   push_idx         in   IDX_WIDTH     index of pushed activation
//   push_data        in   DATA_WIDTH    value of pushed activation
//   queue_rdy        out  1             registered; 1 = free slots > AFULL_MARGIN
//   pop_act          in   1             computation FSM consumes head entry
//   act_out          out  IDX+DATA      head entry {idx,data}; all zeros when queue_empty=1
//   queue_empty      out  1             registered; 1 = no entries stored
//   queue_empty_next out  1             combinational value queue_empty takes after this edge
//   queue_full       out  1             registered; 1 = DEPTH entries stored
//   flush            in   1             layer boundary; discard all entries
//   overflow         out  1             sticky; push was dropped while full; cleared by rst or flush
// BEHAVIOUR
//   - Storage: circular buffer; wr_ptr, rd_ptr of log2(DEPTH) bits; count of log2(DEPTH)+1 bits.
//   - Pointers wrap naturally from DEPTH-1 to 0.
//   - Reset: ptrs=0, count=0, queue_empty=1, queue_full=0, queue_rdy=1, overflow=0, act_out=0.
//   - Storage array itself is not reset.
//   - Effective pop (pop_v) = pop_act & ~queue_empty; pop on empty is ignored, no state change.
//   - Effective push (push_v) = push_act & (~queue_full | pop_v).
//   - A push while full with no simultaneous pop is dropped and sets overflow.
//   - Simultaneous push+pop on full queue: both take effect, count stays DEPTH.
//   - Simultaneous push+pop on empty queue: pop is ignored (no fall-through); push stored, count=1.
//   - count_next = count + push_v - pop_v; empty/full/rdy are registered from count_next.
//   - queue_empty_next = (count_next == 0); always valid, including during flush and rst.
//   - Write latency: an entry pushed at edge N is visible on act_out after edge N (cycle N+1).
//   - act_out = mem[rd_ptr] gated by ~queue_empty; no read latency beyond register storage.
//   - Ordering: strict FIFO; entries are never reordered, merged or filtered.
//   - flush: ptrs=0, count=0, empty=1, full=0, rdy=1, overflow=0 at next edge.
//   - flush: same-cycle push and pop are discarded.
//   - flush: queue_empty_next=1 during the flush cycle.
//   - rst has priority over flush; flush has priority over push/pop.
//   - rst mid-operation discards all entries; no partial entry survives.
//   - queue_rdy = (DEPTH - count_next) > AFULL_MARGIN.
//   - AFULL_MARGIN absorbs router in-flight flits; the network interface may still push while queue_rdy=0.
// TESTING
//   1. Reset, push {idx=5,data=0x0123}:
//      queue_empty_next=1->0 same cycle; next cycle act_out=0x005_0123, queue_empty=0.
//   2. Push 16 entries with idx 0..15 and no pops:
//      queue_full=1 after 16th edge; queue_rdy=0 once count>=14.
//      17th push sets overflow=1 and leaves the head at idx 0.
//   3. Queue full, push idx=99 with simultaneous pop:
//      count stays 16, head advances to idx 1, idx 99 appears last on drain, overflow unchanged.
//   4. Queue empty, push+pop same cycle:
//      pop ignored; next cycle count=1, act_out holds pushed entry.
//   5. Push 40 entries with a random pop pattern:
//      pops return idx 0..39 in order; pointers wrap twice; no spurious overflow.
//   6. Queue holds 7 entries, assert flush with push and pop:
//      next cycle empty=1, count=0, overflow=0, act_out=0. Repeat with rst: same result.

Source files
------------

// File: rtl/pe_act_queue_if.sv
// Bundle between the network interface / computation FSM and the PE activation queue.
// The queue itself attaches through the slave modport.
interface pe_act_queue_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 10
);
  logic                            push_act;
  logic [IDX_WIDTH-1:0]            push_idx;
  logic [DATA_WIDTH-1:0]           push_data;
  logic                            queue_rdy;
  logic                            pop_act;
  logic [IDX_WIDTH+DATA_WIDTH-1:0] act_out;
  logic                            queue_empty;
  logic                            queue_empty_next;
  logic                            queue_full;
  logic                            flush;
  logic                            overflow;

  modport master (
    output push_act, push_idx, push_data, pop_act, flush,
    input  queue_rdy, act_out, queue_empty, queue_empty_next, queue_full, overflow
  );

  modport slave (
    input  push_act, push_idx, push_data, pop_act, flush,
    output queue_rdy, act_out, queue_empty, queue_empty_next, queue_full, overflow
  );
endinterface

// File: rtl/pe_act_queue.sv
// Circular-buffer activation queue feeding the PE computation FSM.
// Registered empty/full/ready flags plus a look-ahead empty flag for the FSM.
module pe_act_queue #(
  parameter int DATA_WIDTH   = 16,
  parameter int IDX_WIDTH    = 10,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic               clk,
  input  logic               rst,
  pe_act_queue_if.slave      bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = IDX_WIDTH + DATA_WIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(DEPTH - AFULL_MARGIN);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             rdy_q, rdy_d;
  logic             overflow_q, overflow_d;
  logic             pop_v, push_v, wr_en;

  // rst and flush are folded in here so queue_empty_next reports 1 during either
  always_comb begin
    pop_v      = bus.pop_act & ~empty_q;
    push_v     = bus.push_act & (~full_q | pop_v);
    wr_en      = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (rst || bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      wr_en      = push_v;
      wr_ptr_d   = wr_ptr_q + PTR_W'(push_v);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop_v);
      count_d    = count_q + CNT_W'(push_v) - CNT_W'(pop_v);
      overflow_d = overflow_q | (bus.push_act & full_q & ~pop_v);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_CNT);
    rdy_d   = (count_d < RDY_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rdy_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      rdy_q      <= rdy_d;
      overflow_q <= overflow_d;
    end
  end

  // On a full push+pop the write lands in the slot being vacated, becoming the new tail
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {bus.push_idx, bus.push_data};
    end
  end

  assign bus.act_out          = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.queue_empty      = empty_q;
  assign bus.queue_empty_next = empty_d;
  assign bus.queue_full       = full_q;
  assign bus.queue_rdy        = rdy_q;
  assign bus.overflow         = overflow_q;
endmodule

// File: tb/tb_pe_act_queue.sv
// Directed bench for pe_act_queue: stimulus pushes expected entries into a scoreboard,
// a negedge monitor pops and compares whenever the FSM side consumes the head.
module tb_pe_act_queue;
  localparam int DW     = 16;
  localparam int IW     = 10;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;
  localparam int EW     = IW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_act_queue_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) q_if ();

  pe_act_queue #(
    .DATA_WIDTH(DW), .IDX_WIDTH(IW), .DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(q_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EW-1:0] sb[$];
  int   mdl_count  = 0;
  logic mdl_ovf    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: an effective pop consumes the scoreboard head
  always @(negedge clk) begin
    if (!rst && !q_if.flush && q_if.pop_act && !q_if.queue_empty) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL pop_unexpected: got 0x%0h expected no entry", q_if.act_out);
      end else begin
        checkOutput("pop_data", 32'(q_if.act_out), 32'(sb.pop_front()));
      end
    end
  end

  task automatic idleInputs();
    q_if.push_act  = 1'b0;
    q_if.push_idx  = '0;
    q_if.push_data = '0;
    q_if.pop_act   = 1'b0;
    q_if.flush     = 1'b0;
  endtask

  task automatic applyStimulus(input logic push, input logic [IW-1:0] idx, input logic [DW-1:0] data,
                               input logic pop, input logic fl);
    int  nxt;
    bit  pv;
    bit  uv;
    q_if.push_act  = push;
    q_if.push_idx  = idx;
    q_if.push_data = data;
    q_if.pop_act   = pop;
    q_if.flush     = fl;
    if (fl) begin
      sb.delete();
      nxt     = 0;
      mdl_ovf = 1'b0;
    end else begin
      pv = pop && (mdl_count > 0);
      uv = push && ((mdl_count < DEPTH) || pv);
      if (push && !uv) mdl_ovf = 1'b1;
      if (uv) sb.push_back({idx, data});
      nxt = mdl_count + int'(uv) - int'(pv);
    end
    #1;
    checkOutput("empty_next", 32'(q_if.queue_empty_next), 32'(nxt == 0));
    mdl_count = nxt;
    @(posedge clk);
    #1;
    idleInputs();
  endtask

  task automatic applyReset(input logic push, input logic pop);
    rst           = 1'b1;
    q_if.push_act = push;
    q_if.push_idx = 10'd3;
    q_if.pop_act  = pop;
    sb.delete();
    mdl_count = 0;
    mdl_ovf   = 1'b0;
    #1;
    checkOutput("rst_empty_next", 32'(q_if.queue_empty_next), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idleInputs();
  endtask

  task automatic checkFlags(input string tag);
    logic [EW-1:0] exp_head;
    exp_head = (mdl_count == 0) ? '0 : sb[0];
    checkOutput({tag, "_empty"},    32'(q_if.queue_empty), 32'(mdl_count == 0));
    checkOutput({tag, "_full"},     32'(q_if.queue_full),  32'(mdl_count == DEPTH));
    checkOutput({tag, "_rdy"},      32'(q_if.queue_rdy),   32'(mdl_count < DEPTH - MARGIN));
    checkOutput({tag, "_overflow"}, 32'(q_if.overflow),    32'(mdl_ovf));
    checkOutput({tag, "_act_out"},  32'(q_if.act_out),     32'(exp_head));
  endtask

  initial begin
    logic [39:0] pat;
    logic [EW-1:0] exp_entry;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkFlags("reset");

    // 1: single push becomes visible one edge later
    checkOutput("t1_empty_next_idle", 32'(q_if.queue_empty_next), 32'd1);
    applyStimulus(1'b1, 10'd5, 16'h0123, 1'b0, 1'b0);
    checkOutput("t1_head", 32'(q_if.act_out), 32'h0050123);
    checkFlags("t1");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkFlags("t1_popped");

    // 2: fill to full, then one dropped push
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, IW'(i), DW'(16'hA000 + i), 1'b0, 1'b0);
      checkFlags($sformatf("t2_%0d", i));
    end
    applyStimulus(1'b1, 10'd16, 16'hA010, 1'b0, 1'b0);
    checkFlags("t2_ovf");

    // 3: push+pop on full queue
    applyStimulus(1'b1, 10'd99, 16'h9999, 1'b1, 1'b0);
    checkFlags("t3");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkFlags("t3_drained");
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
    checkFlags("t3_flushed");

    // 4: push+pop on empty queue, pop ignored
    applyStimulus(1'b1, 10'd7, 16'h0777, 1'b1, 1'b0);
    exp_entry = {10'd7, 16'h0777};
    checkOutput("t4_head", 32'(q_if.act_out), 32'(exp_entry));
    checkFlags("t4");
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);

    // 5: 40 pushes with an irregular pop pattern, then drain
    pat = 40'hF7_BD_EF_7B_DE;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, IW'(i), DW'(16'h5000 + i), pat[i], 1'b0);
    end
    checkFlags("t5_loaded");
    for (int i = 0; i < 40 && mdl_count > 0; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    checkFlags("t5_drained");

    // 6: flush, then reset, each with concurrent push and pop
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, IW'(200 + i), DW'(16'hC000 + i), 1'b0, 1'b0);
    checkFlags("t6_loaded");
    applyStimulus(1'b1, 10'd300, 16'hDEAD, 1'b1, 1'b1);
    checkFlags("t6_flush");
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, IW'(210 + i), DW'(16'hC100 + i), 1'b0, 1'b0);
    applyReset(1'b1, 1'b1);
    checkFlags("t6_rst");

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
